frame_sequencer: RTL and testbench

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

---
 rtl/frame_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_frame_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// Frame sequencer: streams one image frame from pixel memory into a datapath
// in raster order, collects the datapath results into result memory, and
// reports completion, result overflow and drain timeout.
module frame_sequencer #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int OUT_COUNT  = 16,
  parameter int TIMEOUT    = 1024,
  parameter int AW         = $clog2(IMG_WIDTH * IMG_HEIGHT),
  parameter int RW         = $clog2(OUT_COUNT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          pause,
  output logic          busy,
  output logic          done,
  output logic          err_timeout,
  output logic          err_overflow,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          pix_valid,
  output logic [7:0]    pix_data,
  input  logic          res_valid,
  input  logic [7:0]    res_data,
  output logic          res_wr_en,
  output logic [RW-1:0] res_wr_addr,
  output logic [7:0]    res_wr_data
);

  localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int CW   = $clog2(OUT_COUNT + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_FIN
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   rd_cnt_q;
  logic [CW-1:0]   out_cnt_q;
  logic [CW-1:0]   out_cnt_d;
  logic [TW-1:0]   to_q;
  logic [TW-1:0]   to_d;
  logic            rd_vld_q;
  logic            busy_q;
  logic            done_q;
  logic            err_timeout_q;
  logic            err_overflow_q;
  logic            mem_rd_en_q;
  logic [AW-1:0]   mem_rd_addr_q;
  logic            pix_valid_q;
  logic [7:0]      pix_data_q;
  logic            res_wr_en_q;
  logic [RW-1:0]   res_wr_addr_q;
  logic [7:0]      res_wr_data_q;

  logic            in_run;
  logic            res_take;
  logic            res_acc;
  logic            last_rd;
  logic            complete;
  logic            timed_out;

  // Result acceptance, completion and timeout decisions for this cycle.
  always_comb begin
    in_run    = (state_q == S_FEED) || (state_q == S_DRAIN);
    res_take  = in_run && res_valid;
    res_acc   = res_take && (out_cnt_q < CW'(OUT_COUNT));
    out_cnt_d = res_acc ? out_cnt_q + CW'(1) : out_cnt_q;
    // The idle counter is preloaded with 1 so that done appears exactly
    // TIMEOUT cycles after the cycle carrying the last result.
    to_d      = res_valid ? TW'(1) : to_q + TW'(1);
    last_rd   = (rd_cnt_q == AW'(NPIX - 1));
    complete  = (out_cnt_d == CW'(OUT_COUNT));
    timed_out = (to_d == TW'(TIMEOUT));
  end

  // Frame FSM, pixel pipeline and result writer with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      rd_cnt_q       <= '0;
      out_cnt_q      <= '0;
      to_q           <= '0;
      rd_vld_q       <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_overflow_q <= 1'b0;
      mem_rd_en_q    <= 1'b0;
      mem_rd_addr_q  <= '0;
      pix_valid_q    <= 1'b0;
      pix_data_q     <= '0;
      res_wr_en_q    <= 1'b0;
      res_wr_addr_q  <= '0;
      res_wr_data_q  <= '0;
    end else begin
      mem_rd_en_q <= 1'b0;
      res_wr_en_q <= 1'b0;
      done_q      <= 1'b0;

      // Pixel path runs independently of the FSM so no in-flight pixel is lost.
      rd_vld_q    <= mem_rd_en_q;
      pix_valid_q <= rd_vld_q;
      if (rd_vld_q) begin
        pix_data_q <= mem_rd_data;
      end

      if (res_acc) begin
        res_wr_en_q   <= 1'b1;
        res_wr_addr_q <= out_cnt_q[RW-1:0];
        res_wr_data_q <= res_data;
        out_cnt_q     <= out_cnt_d;
      end else if (res_take) begin
        err_overflow_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q        <= S_FEED;
            busy_q         <= 1'b1;
            rd_cnt_q       <= '0;
            out_cnt_q      <= '0;
            to_q           <= '0;
            err_timeout_q  <= 1'b0;
            err_overflow_q <= 1'b0;
          end
        end
        S_FEED: begin
          if (!pause) begin
            mem_rd_en_q   <= 1'b1;
            mem_rd_addr_q <= rd_cnt_q;
            rd_cnt_q      <= rd_cnt_q + AW'(1);
            if (last_rd) begin
              state_q <= S_DRAIN;
              to_q    <= TW'(1);
            end
          end
        end
        S_DRAIN: begin
          to_q <= to_d;
          if (complete) begin
            state_q <= S_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (timed_out) begin
            state_q       <= S_FIN;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
            err_timeout_q <= 1'b1;
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err_timeout  = err_timeout_q;
  assign err_overflow = err_overflow_q;
  assign mem_rd_en    = mem_rd_en_q;
  assign mem_rd_addr  = mem_rd_addr_q;
  assign pix_valid    = pix_valid_q;
  assign pix_data     = pix_data_q;
  assign res_wr_en    = res_wr_en_q;
  assign res_wr_addr  = res_wr_addr_q;
  assign res_wr_data  = res_wr_data_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed testbench for frame_sequencer with default parameters.
module tb_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       res_valid = 1'b0;
  logic [7:0] res_data = 8'h00;
  logic [7:0] mem_rd_data;
  logic       busy, done, err_timeout, err_overflow;
  logic       mem_rd_en, pix_valid, res_wr_en;
  logic [5:0] mem_rd_addr;
  logic [7:0] pix_data, res_wr_data;
  logic [3:0] res_wr_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Pixel memory: byte value equals its address, one-cycle read latency.
  always @(posedge clk) mem_rd_data <= {2'b00, mem_rd_addr};

  frame_sequencer #(
    .IMG_WIDTH (8),
    .IMG_HEIGHT(8),
    .OUT_COUNT (16),
    .TIMEOUT   (1024)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pause       (pause),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout),
    .err_overflow(err_overflow),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_wr_en   (res_wr_en),
    .res_wr_addr (res_wr_addr),
    .res_wr_data (res_wr_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int j, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s j=%0d got=%0h want=%0h", tag, j, obs, exp);
    end
  endtask

  task automatic chk_all(input string f, input int j,
                         input bit e_rd, input int e_addr, input bit e_pv, input int e_pd,
                         input bit e_wr, input int e_wa, input int e_wd,
                         input bit e_busy, input bit e_done, input bit e_to, input bit e_ov);
    chk({f, ".rd_en"}, j, 32'(mem_rd_en), 32'(e_rd));
    if (e_rd) chk({f, ".rd_addr"}, j, 32'(mem_rd_addr), e_addr);
    chk({f, ".pix_valid"}, j, 32'(pix_valid), 32'(e_pv));
    if (e_pv) chk({f, ".pix_data"}, j, 32'(pix_data), e_pd);
    chk({f, ".wr_en"}, j, 32'(res_wr_en), 32'(e_wr));
    if (e_wr) begin
      chk({f, ".wr_addr"}, j, 32'(res_wr_addr), e_wa);
      chk({f, ".wr_data"}, j, 32'(res_wr_data), e_wd);
    end
    chk({f, ".busy"}, j, 32'(busy), 32'(e_busy));
    chk({f, ".done"}, j, 32'(done), 32'(e_done));
    chk({f, ".err_to"}, j, 32'(err_timeout), 32'(e_to));
    chk({f, ".err_ov"}, j, 32'(err_overflow), 32'(e_ov));
  endtask

  initial begin
    bit rd, pv;
    int ad, pd;

    // Reset state
    step();
    step();
    chk_all("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst.rd_addr", 0, 32'(mem_rd_addr), 0);
    chk("rst.wr_addr", 0, 32'(res_wr_addr), 0);
    rst_n = 1'b1;
    step();

    // Frame A: full stream, 16 results 0xA0..0xAF during FEED
    start = 1'b1;
    for (int j = 1; j <= 80; j++) begin
      step();
      start = 1'b0;
      chk_all("A", j, (j >= 2 && j <= 65), j - 2, (j >= 4 && j <= 67), j - 4,
              (j >= 11 && j <= 26), j - 11, 8'hA0 + j - 11,
              (j >= 1 && j <= 65), (j == 66), 0, 0);
      res_valid = (j >= 10 && j <= 25);
      res_data  = 8'(8'hA0 + j - 10);
    end
    res_valid = 1'b0;

    // Frame B: pause before addr 10 for 5 cycles, 3 results in DRAIN, then timeout
    start = 1'b1;
    for (int j = 1; j <= 1105; j++) begin
      step();
      rd = (j >= 2 && j <= 11) || (j >= 17 && j <= 70);
      ad = (j <= 11) ? j - 2 : j - 7;
      pv = (j >= 4 && j <= 13) || (j >= 19 && j <= 72);
      pd = (j <= 13) ? j - 4 : j - 9;
      chk_all("B", j, rd, ad, pv, pd,
              (j >= 75 && j <= 77), j - 75, 8'h11 + j - 75,
              (j >= 1 && j <= 1099), (j == 1100), (j >= 1100), 0);
      start     = (j >= 499 && j <= 501);
      pause     = (j >= 11 && j <= 15);
      res_valid = (j >= 74 && j <= 76);
      res_data  = 8'(8'h11 + j - 74);
    end
    res_valid = 1'b0;
    pause     = 1'b0;

    // Frame C: 17 results -> overflow; start held across FIN begins frame D
    start = 1'b1;
    for (int j = 1; j <= 99; j++) begin
      step();
      rd = (j >= 2 && j <= 65) || (j >= 69);
      ad = (j <= 65) ? j - 2 : j - 69;
      pv = (j >= 4 && j <= 67) || (j >= 71);
      pd = (j <= 67) ? j - 4 : j - 71;
      chk_all("C", j, rd, ad, pv, pd,
              (j >= 11 && j <= 26), j - 11, 8'h50 + j - 11,
              (j >= 1 && j <= 65) || (j >= 68), (j == 66), 0, (j >= 27 && j <= 67));
      start     = (j >= 60 && j <= 67);
      res_valid = (j >= 10 && j <= 26);
      res_data  = 8'(8'h50 + j - 10);
    end
    res_valid = 1'b0;
    start     = 1'b0;

    // Asynchronous reset while read address 30 is on the bus
    chk("D.addr30", 99, 32'(mem_rd_addr), 30);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("rstD", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rstD.rd_addr", 0, 32'(mem_rd_addr), 0);
    chk("rstD.pix_data", 0, 32'(pix_data), 0);
    chk("rstD.wr_addr", 0, 32'(res_wr_addr), 0);
    chk("rstD.wr_data", 0, 32'(res_wr_data), 0);
    for (int j = 1; j <= 3; j++) begin
      step();
      chk("rstD.hold_done", j, 32'(done), 0);
      chk("rstD.hold_rd", j, 32'(mem_rd_en), 0);
    end
    rst_n = 1'b1;
    step();
    chk_all("idleE", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Frame E: restarts from address 0
    start = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      step();
      start = 1'b0;
      chk_all("E", j, (j >= 2), j - 2, (j >= 4), j - 4, 0, 0, 0, 1, 0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
